// File: rtl/add11_operand_stage_if.sv
// Operand/result bundle for add11_operand_stage: producer side, external adder
// loop and consumer side. The stage itself uses the slave modport.
interface add11_operand_stage_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [10:0]      in_x;
  logic [10:0]      in_y;
  logic [10:0]      adder_x;
  logic [10:0]      adder_y;
  logic [11:0]      adder_s;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      out_sum;
  logic             out_carry;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output in_valid, in_x, in_y, adder_s, out_ready,
    input  in_ready, adder_x, adder_y, out_valid, out_sum, out_carry,
           level, carry_cnt
  );

  modport slave (
    input  in_valid, in_x, in_y, adder_s, out_ready,
    output in_ready, adder_x, adder_y, out_valid, out_sum, out_carry,
           level, carry_cnt
  );
endinterface

// File: rtl/add11_operand_stage.sv
// Operand FIFO feeding an external 11-bit adder, with a registered result and a
// saturating carry counter. Latency 1 cycle min, 1/cycle; in_ready drops only when the FIFO is full.
module add11_operand_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  add11_operand_stage_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [21:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             out_valid;
  logic [11:0]      out_sum;
  logic [CNT_W-1:0] carry_cnt;
  logic [1:0]       rst_sync;
  logic             run;
  logic             not_full;
  logic             not_empty;
  logic             push;
  logic             issue;
  logic             deliver;
  logic [21:0]      head;

  // Release from reset is re-timed so no transfer lands in the edge where rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run       = rst_sync[1];
  assign not_full  = (level != LVL_W'(DEPTH));
  assign not_empty = (level != '0);
  assign push      = run & bus.in_valid & not_full;
  assign issue     = run & not_empty & (~out_valid | bus.out_ready);
  assign deliver   = out_valid & bus.out_ready;
  assign head      = mem[rd_ptr];

  // Storage holds no control meaning, so it stays out of the reset domain.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_x, bus.in_y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, issue})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      if (issue) begin
        out_valid <= 1'b1;
        out_sum   <= bus.adder_s;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (deliver && out_sum[11] && (carry_cnt != {CNT_W{1'b1}})) begin
      carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

  // The adder sees zeros whenever there is nothing valid at the head.
  assign bus.adder_x   = not_empty ? head[21:11] : 11'd0;
  assign bus.adder_y   = not_empty ? head[10:0]  : 11'd0;
  assign bus.in_ready  = not_full;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_carry = out_sum[11];
  assign bus.level     = level;
  assign bus.carry_cnt = carry_cnt;
endmodule

// File: tb/tb_add11_operand_stage.sv
// Directed bench for add11_operand_stage: a DEPTH=4/CNT_W=8 instance for the
// main checks and a CNT_W=2 instance for counter saturation.
module tb_add11_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;

  add11_operand_stage_if #(.DEPTH(4), .CNT_W(8)) bus ();
  add11_operand_stage_if #(.DEPTH(4), .CNT_W(2)) bus2 ();

  add11_operand_stage #(.DEPTH(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  add11_operand_stage #(.DEPTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // External combinational adders
  assign bus.adder_s  = {1'b0, bus.adder_x} + {1'b0, bus.adder_y};
  assign bus2.adder_s = {1'b0, bus2.adder_x} + {1'b0, bus2.adder_y};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick; tick; tick;
  endtask

  logic [10:0] fx [6] = '{11'd1, 11'd2047, 11'd500, 11'd1500, 11'd0, 11'd1234};
  logic [10:0] fy [6] = '{11'd2, 11'd1, 11'd600, 11'd1500, 11'd2047, 11'd4};
  logic [11:0] fs [6] = '{12'd3, 12'd2048, 12'd1100, 12'd3000, 12'd2047, 12'd1238};
  logic [1:0]  sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  logic [11:0] q [$];
  logic [11:0] held;
  logic [11:0] exp_s;
  bit          rdy, dlv, acc, stalled;
  int          idx, got, sent, valid_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_x = '0; bus2.in_y = '0; bus2.out_ready = 1'b0;

    // Reset state before any clock edge
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_carry_cnt", bus.carry_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_adder_x", bus.adder_x, 0);
    chk("rst_adder_y", bus.adder_y, 0);
    apply_reset;

    // Max operands: accept at edge k, result visible after edge k+1
    bus.out_ready = 1'b1;
    bus.in_x = 11'd2047; bus.in_y = 11'd2047; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk("max_level", bus.level, 1);
    chk("max_no_bypass", bus.out_valid, 0);
    chk("max_adder_x", bus.adder_x, 2047);
    tick;
    chk("max_out_valid", bus.out_valid, 1);
    chk("max_out_sum", bus.out_sum, 12'hFFE);
    chk("max_out_carry", bus.out_carry, 1);
    tick;
    chk("max_carry_cnt", bus.carry_cnt, 1);
    chk("max_drained", bus.out_valid, 0);

    // Zero and no-carry pair, in order
    apply_reset;
    bus.out_ready = 1'b1;
    bus.in_x = 11'd0; bus.in_y = 11'd0; bus.in_valid = 1'b1;
    tick;
    bus.in_x = 11'd1024; bus.in_y = 11'd1023;
    tick;
    bus.in_valid = 1'b0;
    chk("zero_valid", bus.out_valid, 1);
    chk("zero_sum", bus.out_sum, 0);
    chk("zero_carry", bus.out_carry, 0);
    tick;
    chk("nc_valid", bus.out_valid, 1);
    chk("nc_sum", bus.out_sum, 2047);
    chk("nc_carry", bus.out_carry, 0);
    tick;
    chk("nc_carry_cnt", bus.carry_cnt, 0);

    // Fill with consumer stalled: DEPTH+1 accepted, sixth held
    apply_reset;
    bus.out_ready = 1'b0;
    idx = 0;
    bus.in_x = fx[0]; bus.in_y = fy[0]; bus.in_valid = 1'b1;
    repeat (8) begin
      rdy = bus.in_ready;
      tick;
      if (rdy && bus.in_valid) begin
        idx++;
        if (idx < 6) begin bus.in_x = fx[idx]; bus.in_y = fy[idx]; end
        else bus.in_valid = 1'b0;
      end
    end
    chk("fill_accepted", idx, 5);
    chk("fill_in_ready", bus.in_ready, 0);
    chk("fill_level", bus.level, 4);
    chk("fill_out_valid", bus.out_valid, 1);
    chk("fill_head_sum", bus.out_sum, fs[0]);
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      dlv = bus.out_valid;
      rdy = bus.in_ready;
      if (dlv) chk($sformatf("fill_res%0d", got), bus.out_sum, fs[got]);
      tick;
      if (dlv) got++;
      if (rdy && bus.in_valid) begin idx++; bus.in_valid = 1'b0; end
    end
    chk("fill_count", got, 6);
    chk("fill_all_in", idx, 6);

    // Streaming 100 random pairs with out_ready toggling
    apply_reset;
    q.delete();
    sent = 0; got = 0;
    bus.in_x = 11'($urandom_range(0, 2047));
    bus.in_y = 11'($urandom_range(0, 2047));
    bus.in_valid = 1'b1;
    for (int c = 0; c < 1000 && got < 100; c++) begin
      bus.out_ready = (c % 2 == 0);
      #0;
      acc = bus.in_valid && bus.in_ready;
      dlv = bus.out_valid && bus.out_ready;
      stalled = bus.out_valid && !bus.out_ready;
      held = bus.out_sum;
      if (acc) q.push_back({1'b0, bus.in_x} + {1'b0, bus.in_y});
      if (dlv) begin
        exp_s = (q.size() > 0) ? q.pop_front() : 12'hxxx;
        chk($sformatf("stream_res%0d", got), bus.out_sum, exp_s);
        got++;
      end
      tick;
      if (acc) begin
        sent++;
        if (sent < 100) begin
          bus.in_x = 11'($urandom_range(0, 2047));
          bus.in_y = 11'($urandom_range(0, 2047));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (stalled) begin
        chk("stream_hold_valid", bus.out_valid, 1);
        chk("stream_hold_sum", bus.out_sum, held);
      end
    end
    chk("stream_count", got, 100);
    bus.out_ready = 1'b0;

    // Reset mid-stream with level=3 and a pending result
    apply_reset;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_x = fx[i]; bus.in_y = fy[i];
      tick;
    end
    bus.in_valid = 1'b0;
    chk("mid_level", bus.level, 3);
    chk("mid_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_sum", bus.out_sum, 0);
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_adder_x", bus.adder_x, 0);
    tick;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    valid_seen = 0;
    repeat (10) begin
      tick;
      if (bus.out_valid) valid_seen++;
    end
    chk("mid_post_valid", valid_seen, 0);
    chk("mid_post_level", bus.level, 0);

    // Carry counter saturation on the CNT_W=2 instance
    apply_reset;
    bus2.out_ready = 1'b1;
    bus2.in_x = 11'd2047; bus2.in_y = 11'd1;
    idx = 0; got = 0;
    bus2.in_valid = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      acc = bus2.in_valid && bus2.in_ready;
      dlv = bus2.out_valid && bus2.out_ready;
      if (dlv) chk($sformatf("sat_sum%0d", got), bus2.out_sum, 12'h800);
      tick;
      if (acc) begin idx++; if (idx == 5) bus2.in_valid = 1'b0; end
      if (dlv) begin
        chk($sformatf("sat_cnt%0d", got), bus2.carry_cnt, sat_exp[got]);
        got++;
      end
    end
    chk("sat_count", got, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
